modbus_tx_frame_ctrl: RTL and testbench

Sequences one Modbus RTU response frame out through the UART byte transmitter. On request it:
- reads N payload bytes from a synchronous frame buffer;
- hands each byte to the transmitter using its rising-edge start / done-pulse handshake;
- appends the CRC-16 (optional);
- enforces the 3.5-character inter-frame silence before reporting completion.

It sits between the RTU protocol engine and the byte transmitter.

---
 rtl/modbus_tx_frame_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_modbus_tx_frame_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/modbus_tx_frame_ctrl.sv
// Modbus RTU response framer: streams frame-buffer bytes into the UART byte transmitter, then holds the 3.5-char silence.
// Define MODBUS_TX_CRC_APPEND_EN to accumulate the CRC-16 and append it (low byte first) after the payload.
module modbus_tx_frame_ctrl #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] frame_len,
  output logic [ADDR_W-1:0] buf_rd_addr,
  input  logic [7:0]        buf_rd_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_state,
  input  logic              tx_done,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       crc_out
);

  // Slow lines use 38.5 bit times; fast lines use the fixed 1.75 ms floor.
  localparam logic [31:0] GAP_CYC = (BAUD_RATE <= 32'd19200) ?
                                    32'((CLK_FREQ / BAUD_RATE) * 77 / 2) :
                                    32'(CLK_FREQ / 1000000 * 1750);

`ifdef MODBUS_TX_CRC_APPEND_EN
  typedef enum logic [3:0] {IDLE, FETCH, LOAD, START, WAIT, CRC_LO, CRC_HI, GAP, DONE} state_t;
  typedef enum logic [1:0] {PH_PAY, PH_LO, PH_HI} phase_t;
`else
  typedef enum logic [3:0] {IDLE, FETCH, LOAD, START, WAIT, GAP, DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [31:0]       gap_cnt_q, gap_cnt_d;
  logic              st_cnt_q, st_cnt_d;
  logic              seen_q, seen_d;
  logic              busy_q, frame_done_q, tx_start_q;
  logic [ADDR_W:0]   nxt_idx;
  logic              more_bytes;

`ifdef MODBUS_TX_CRC_APPEND_EN
  logic [15:0] crc_q, crc_d;
  logic [15:0] crc_out_q, crc_out_d;
  phase_t      phase_q, phase_d;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction
`endif

  assign nxt_idx    = {1'b0, addr_q} + {{ADDR_W{1'b0}}, 1'b1};
  assign more_bytes = (nxt_idx < {1'b0, len_q});

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    addr_d    = addr_q;
    tx_data_d = tx_data_q;
    gap_cnt_d = gap_cnt_q;
    // Handshake trackers only live inside START; cleared everywhere else so each byte starts fresh.
    st_cnt_d  = (state_q == START);
    seen_d    = (state_q == START) && (seen_q || tx_state);
`ifdef MODBUS_TX_CRC_APPEND_EN
    crc_d     = crc_q;
    crc_out_d = crc_out_q;
    phase_d   = phase_q;
`endif
    case (state_q)
      IDLE: begin
        if (frame_start && (frame_len != '0)) begin
          len_d   = frame_len;
          addr_d  = '0;
          state_d = FETCH;
`ifdef MODBUS_TX_CRC_APPEND_EN
          crc_d   = 16'hFFFF;
          phase_d = PH_PAY;
`endif
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        tx_data_d = buf_rd_data;
`ifdef MODBUS_TX_CRC_APPEND_EN
        crc_d     = crc16_byte(crc_q, buf_rd_data);
`endif
        state_d   = START;
      end
      START: begin
        // Two cycles minimum high so the transmitter's synchroniser cannot miss the edge.
        if (st_cnt_q && (seen_q || tx_state)) state_d = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          gap_cnt_d = '0;
`ifdef MODBUS_TX_CRC_APPEND_EN
          case (phase_q)
            PH_PAY: begin
              if (more_bytes) begin
                addr_d  = nxt_idx[ADDR_W-1:0];
                state_d = FETCH;
              end else begin
                state_d = CRC_LO;
              end
            end
            PH_LO:   state_d = CRC_HI;
            default: state_d = GAP;
          endcase
`else
          if (more_bytes) begin
            addr_d  = nxt_idx[ADDR_W-1:0];
            state_d = FETCH;
          end else begin
            state_d = GAP;
          end
`endif
        end
      end
`ifdef MODBUS_TX_CRC_APPEND_EN
      CRC_LO: begin
        tx_data_d = crc_q[7:0];
        phase_d   = PH_LO;
        state_d   = START;
      end
      CRC_HI: begin
        tx_data_d = crc_q[15:8];
        phase_d   = PH_HI;
        state_d   = START;
      end
`endif
      GAP: begin
        if ((gap_cnt_q + 32'd1) >= GAP_CYC) begin
          state_d = DONE;
`ifdef MODBUS_TX_CRC_APPEND_EN
          crc_out_d = crc_q;
`endif
        end else begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      len_q        <= '0;
      addr_q       <= '0;
      tx_data_q    <= '0;
      gap_cnt_q    <= '0;
      st_cnt_q     <= 1'b0;
      seen_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      tx_start_q   <= 1'b0;
`ifdef MODBUS_TX_CRC_APPEND_EN
      crc_q        <= 16'hFFFF;
      crc_out_q    <= 16'hFFFF;
      phase_q      <= PH_PAY;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      tx_data_q    <= tx_data_d;
      gap_cnt_q    <= gap_cnt_d;
      st_cnt_q     <= st_cnt_d;
      seen_q       <= seen_d;
      // Outputs are registered from the next state so they line up with it and never glitch.
      busy_q       <= (state_d != IDLE) && (state_d != DONE);
      frame_done_q <= (state_d == DONE);
      tx_start_q   <= (state_d == START);
`ifdef MODBUS_TX_CRC_APPEND_EN
      crc_q        <= crc_d;
      crc_out_q    <= crc_out_d;
      phase_q      <= phase_d;
`endif
    end
  end

  assign buf_rd_addr = addr_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
`ifdef MODBUS_TX_CRC_APPEND_EN
  assign crc_out     = crc_out_q;
`else
  assign crc_out     = 16'hFFFF;
`endif

endmodule

// File: tb/tb_modbus_tx_frame_ctrl.sv
// Directed bench for modbus_tx_frame_ctrl with a behavioural byte transmitter and a sampling line monitor.
// 192 kHz / 19200 baud gives 10 clk per bit and a 385-cycle gap on the 38.5-bit-time branch.
module tb_modbus_tx_frame_ctrl;

  localparam int ADDR_W    = 8;
  localparam int CLK_FREQ  = 192000;
  localparam int BAUD_RATE = 19200;
  localparam int BIT_CLK   = 10;
  localparam int GAP_CYC   = 385;
`ifdef MODBUS_TX_CRC_APPEND_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic              frame_start;
  logic [ADDR_W-1:0] frame_len;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic [7:0]        buf_rd_data;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_state;
  logic              tx_done;
  logic              busy;
  logic              frame_done;
  logic [15:0]       crc_out;

  always #5 clk_in = ~clk_in;

  modbus_tx_frame_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .ADDR_W(ADDR_W)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .frame_start(frame_start), .frame_len(frame_len),
    .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data), .tx_start(tx_start), .tx_data(tx_data),
    .tx_state(tx_state), .tx_done(tx_done), .busy(busy), .frame_done(frame_done), .crc_out(crc_out)
  );

  logic [7:0] mem [256];
  always @(posedge clk_in) buf_rd_data <= mem[buf_rd_addr];

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Byte transmitter: 2-flop edge detect on tx_start, 8N1 framing, done pulse after the stop bit.
  logic       s1, s2, uart_line;
  logic [9:0] sh;
  int         bitc, clkc;
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1 <= 1'b0; s2 <= 1'b0; tx_state <= 1'b0; tx_done <= 1'b0; uart_line <= 1'b1;
      sh <= '0; bitc <= 0; clkc <= 0;
    end else begin
      s1 <= tx_start; s2 <= s1; tx_done <= 1'b0;
      if (!tx_state) begin
        if (s1 && !s2) begin
          tx_state <= 1'b1; sh <= {1'b1, tx_data, 1'b0}; uart_line <= 1'b0; bitc <= 0; clkc <= 0;
        end
      end else if (clkc == BIT_CLK - 1) begin
        clkc <= 0;
        if (bitc == 9) begin
          tx_state <= 1'b0; tx_done <= 1'b1;
        end else begin
          bitc <= bitc + 1; uart_line <= sh[bitc + 1];
        end
      end else begin
        clkc <= clkc + 1;
      end
    end
  end

  // Line monitor: samples mid-bit on the falling clock edge.
  logic [7:0] rx_q [$];
  logic [7:0] rx_b;
  always begin
    @(negedge uart_line);
    repeat (BIT_CLK / 2) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      repeat (BIT_CLK) @(negedge clk_in);
      rx_b[i] = uart_line;
    end
    repeat (BIT_CLK) @(negedge clk_in);
    rx_q.push_back(rx_b);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  function automatic logic [63:0] rx_packed();
    logic [63:0] v;
    v = '0;
    foreach (rx_q[i]) v = {v[55:0], rx_q[i]};
    return v;
  endfunction

  task automatic start_frame(input logic [7:0] len);
    @(negedge clk_in);
    frame_start = 1'b1; frame_len = len;
    @(negedge clk_in);
    frame_start = 1'b0; frame_len = '0;
  endtask

  task automatic wait_fd(input int budget, output bit ok, output int busy_low);
    ok = 1'b0; busy_low = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk_in);
      if (frame_done) ok = 1'b1;
      else if (!busy) busy_low++;
    end
  endtask

  bit          ok;
  int          nd, blow, gap_act, fd_cyc, cdone, fd_extra, busy_hi, start_hi;
  logic [15:0] c4, c5, ca, cb;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_in = 1'b0; frame_start = 1'b0; frame_len = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk_in);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_addr", buf_rd_addr, 8'h00);
    check("rst_crc_out", crc_out, 16'hFFFF);
    rst_n_in = 1'b1;
    repeat (3) @(negedge clk_in);

    // Classic read-holding-register request 01 03 00 00 00 01 -> CRC 0x0A84.
    mem[0] = 8'h01; mem[1] = 8'h03; mem[2] = 8'h00; mem[3] = 8'h00; mem[4] = 8'h00; mem[5] = 8'h01;
    rx_q.delete();
    start_frame(8'd6);
    check("s1_busy_acc", busy, 1'b1);
    nd = 0; blow = 0;
    for (int i = 0; i < 3000 && nd < (CRC_EN ? 8 : 6); i++) begin
      @(negedge clk_in);
      if (!busy) blow++;
      if (tx_done) nd++;
    end
    check("s1_txdone_cnt", nd, CRC_EN ? 8 : 6);
    cdone = cyc; gap_act = 0; fd_extra = 0;
    for (int i = 0; i < GAP_CYC - 10; i++) begin
      @(negedge clk_in);
      if (!busy) blow++;
      if (tx_start || !uart_line) gap_act++;
      if (frame_done) fd_extra++;
    end
    frame_start = 1'b1; frame_len = 8'd3;
    ok = 1'b0; fd_cyc = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk_in);
      frame_start = 1'b0; frame_len = '0;
      if (frame_done) begin
        ok = 1'b1; fd_cyc = cyc;
      end else begin
        if (!busy) blow++;
        if (tx_start || !uart_line) gap_act++;
      end
    end
    check("s1_frame_done_seen", ok, 1'b1);
    check("s1_busy_throughout", blow, 0);
    check("s2_gap_cycles", fd_cyc - cdone, GAP_CYC + 1);
    check("s2_gap_line_quiet", gap_act, 0);
    check("s2_no_early_done", fd_extra, 0);
    check("s1_crc_out", crc_out, CRC_EN ? 16'h0A84 : 16'hFFFF);
    check("s1_rx_count", rx_q.size(), CRC_EN ? 8 : 6);
    check("s1_rx_bytes", rx_packed(), CRC_EN ? 64'h010300000001840A : 64'h0000010300000001);
    busy_hi = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      if (frame_done) fd_extra++;
      if (busy) busy_hi++;
    end
    check("s1_single_pulse", fd_extra, 0);
    check("s2_gap_start_ignored", busy_hi, 0);

    // Zero-length request must be dropped.
    start_frame(8'd0);
    busy_hi = 0; start_hi = 0; fd_extra = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_hi++;
      if (tx_start) start_hi++;
      if (frame_done) fd_extra++;
      @(negedge clk_in);
    end
    check("s3_len0_busy", busy_hi, 0);
    check("s3_len0_tx_start", start_hi, 0);
    check("s3_len0_frame_done", fd_extra, 0);

    // Single byte frame.
    mem[0] = 8'hA5;
    c4 = crc_upd(16'hFFFF, 8'hA5);
    rx_q.delete();
    start_frame(8'd1);
    wait_fd(1500, ok, blow);
    check("s4_frame_done_seen", ok, 1'b1);
    check("s4_busy_throughout", blow, 0);
    check("s4_rx_count", rx_q.size(), CRC_EN ? 3 : 1);
    check("s4_rx_bytes", rx_packed(), CRC_EN ? {40'h0, 8'hA5, c4[7:0], c4[15:8]} : {56'h0, 8'hA5});
    check("s4_crc_out", crc_out, CRC_EN ? c4 : 16'hFFFF);

    // Reset while the third byte is on the line, then a clean 2-byte frame.
    mem[0] = 8'h01;
    start_frame(8'd6);
    nd = 0;
    for (int i = 0; i < 600 && nd < 2; i++) begin
      @(negedge clk_in);
      if (tx_done) nd++;
    end
    check("s5_two_bytes_out", nd, 2);
    repeat (30) @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    check("s5_rst_busy", busy, 1'b0);
    check("s5_rst_tx_start", tx_start, 1'b0);
    check("s5_rst_line", uart_line, 1'b1);
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (120) @(negedge clk_in);
    rx_q.delete();
    c5 = crc_upd(crc_upd(16'hFFFF, 8'h01), 8'h03);
    start_frame(8'd2);
    wait_fd(2000, ok, blow);
    check("s5_frame_done_seen", ok, 1'b1);
    check("s5_rx_count", rx_q.size(), CRC_EN ? 4 : 2);
    check("s5_rx_bytes", rx_packed(), CRC_EN ? {32'h0, 16'h0103, c5[7:0], c5[15:8]} : {48'h0, 16'h0103});
    check("s5_crc_out", crc_out, CRC_EN ? c5 : 16'hFFFF);

    // Back-to-back frames: the second start lands in the cycle after frame_done.
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    ca = crc_upd(crc_upd(crc_upd(16'hFFFF, 8'h11), 8'h22), 8'h33);
    cb = crc_upd(crc_upd(16'hFFFF, 8'h5A), 8'hC3);
    rx_q.delete();
    start_frame(8'd3);
    wait_fd(2500, ok, blow);
    check("s6a_frame_done_seen", ok, 1'b1);
    check("s6a_rx_bytes", rx_packed(), CRC_EN ? {24'h0, 24'h112233, ca[7:0], ca[15:8]} : {40'h0, 24'h112233});
    mem[0] = 8'h5A; mem[1] = 8'hC3;
    rx_q.delete();
    start_frame(8'd2);
    check("s6b_accepted", busy, 1'b1);
    wait_fd(2000, ok, blow);
    check("s6b_frame_done_seen", ok, 1'b1);
    check("s6b_busy_throughout", blow, 0);
    check("s6b_rx_count", rx_q.size(), CRC_EN ? 4 : 2);
    check("s6b_rx_bytes", rx_packed(), CRC_EN ? {32'h0, 16'h5AC3, cb[7:0], cb[15:8]} : {48'h0, 16'h5AC3});
    check("s6b_crc_out", crc_out, CRC_EN ? cb : 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
